// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared constants and state encoding for instruction_cache
package icache_pkg;

  localparam int WORD_W     = 16;
  localparam int LINE_WORDS = 4;
  localparam int LINE_W     = WORD_W * LINE_WORDS;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_FILL = 1'b1;

endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - tag/data/valid storage: one combinational read port, one write port, clear-all
module icache_array
  import icache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [LINE_W-1:0] rd_data,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_data,
  input  logic              wr_valid
);

  logic [LINE_W-1:0] data_mem [LINES];
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINES-1:0]  valid_q, valid_d;

  // Clear first so a poisoned write landing with the clear stays invalid.
  always_comb begin
    valid_d = clr ? '0 : valid_q;
    if (wr_en) valid_d[wr_idx] = wr_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_idx] <= wr_data;
      tag_mem[wr_idx]  <= wr_tag;
    end
  end

  assign rd_data  = data_mem[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_valid = valid_q[rd_idx];

endmodule

// File: rtl/instruction_cache.sv
// rtl/instruction_cache.sv - direct-mapped read-only instruction cache with 16-bit line fill
module instruction_cache
  import icache_pkg::*;
#(
  parameter int LINES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic [31:0]       fetch_addr,
  input  logic              inv,
  output logic [LINE_W-1:0] cache_dat,
  output logic              cache_wait,
  output logic              mem_rd,
  output logic [31:0]       mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_wait
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;
  localparam int BUF_W = WORD_W * (LINE_WORDS - 1);

  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  assign fetch_idx = fetch_addr[IDX_W+1:2];
  assign fetch_tag = fetch_addr[31:IDX_W+2];

  state_t            state_q, state_d;
  logic [29:0]       fill_line_q, fill_line_d;
  logic [1:0]        beat_q, beat_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic              mem_rd_q, mem_rd_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic              poison_q, poison_d;

  logic [LINE_W-1:0] rd_data;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_valid;
  logic              hit;
  logic              beat_ok;
  logic              fill_done;
  logic [31:0]       line_base;

  assign hit       = (state_q == ST_IDLE) && rd_valid && (rd_tag == fetch_tag);
  assign beat_ok   = mem_rd_q && !mem_wait;
  assign fill_done = (state_q == ST_FILL) && beat_ok && (beat_q == 2'd3);
  assign line_base = fetch_addr & ~32'd3;

  always_comb begin
    state_d     = state_q;
    fill_line_d = fill_line_q;
    beat_d      = beat_q;
    buf_d       = buf_q;
    mem_rd_d    = mem_rd_q;
    mem_addr_d  = mem_addr_q;
    poison_d    = poison_q;
    case (state_q)
      ST_IDLE: begin
        // An inv coinciding with a miss only clears valids; the new fill is clean.
        if (fetch_en && !hit) begin
          fill_line_d = fetch_addr[31:2];
          beat_d      = 2'd0;
          mem_rd_d    = 1'b1;
          mem_addr_d  = line_base;
          poison_d    = 1'b0;
          state_d     = ST_FILL;
        end
      end
      default: begin
        poison_d = poison_q | inv;
        if (beat_ok) begin
          if (beat_q == 2'd3) begin
            beat_d   = 2'd0;
            mem_rd_d = 1'b0;
            poison_d = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            for (int k = 0; k < LINE_WORDS - 1; k++) begin
              if (beat_q == k[1:0]) buf_d[k*WORD_W +: WORD_W] = mem_rdata;
            end
            beat_d     = beat_q + 2'd1;
            mem_addr_d = {fill_line_q, beat_q + 2'd1};
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      fill_line_q <= '0;
      beat_q      <= '0;
      buf_q       <= '0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      poison_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_line_q <= fill_line_d;
      beat_q      <= beat_d;
      buf_q       <= buf_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      poison_q    <= poison_d;
    end
  end

  // The final beat bypasses the buffer so the line is written on its accepting edge.
  icache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .clr      (inv),
    .rd_idx   (fetch_idx),
    .rd_data  (rd_data),
    .rd_tag   (rd_tag),
    .rd_valid (rd_valid),
    .wr_en    (fill_done),
    .wr_idx   (fill_line_q[IDX_W-1:0]),
    .wr_tag   (fill_line_q[29:IDX_W]),
    .wr_data  ({mem_rdata, buf_q}),
    .wr_valid (!(poison_q || inv))
  );

  assign cache_dat  = rd_data;
  assign cache_wait = (state_q == ST_IDLE) ? (fetch_en && !hit) : fetch_en;
  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_instruction_cache.sv
// tb/tb_instruction_cache.sv - scoreboard bench for instruction_cache with RAM and residency models
module tb_instruction_cache;

  localparam int LINES = 16;
  localparam int IDX_W = 4;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic [31:0] fetch_addr;
  logic        inv;
  logic [63:0] cache_dat;
  logic        cache_wait;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_wait;

  instruction_cache #(.LINES(LINES)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_en   (fetch_en),
    .fetch_addr (fetch_addr),
    .inv        (inv),
    .cache_dat  (cache_dat),
    .cache_wait (cache_wait),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_wait   (mem_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  // RAM contents: the first four words match the directed cold-miss values.
  function automatic logic [15:0] ram_word(input logic [31:0] a);
    logic [31:0] h;
    if (a < 32'd4) return 16'h1111 * (a[15:0] + 16'd1);
    h = a * 32'h9e3779b1;
    return h[31:16] ^ h[15:0];
  endfunction

  function automatic logic [63:0] line_data(input logic [29:0] l);
    logic [63:0] d;
    for (int k = 0; k < 4; k++) d[k*16 +: 16] = ram_word({l, k[1:0]});
    return d;
  endfunction

  assign mem_rdata = ram_word(mem_addr);

  typedef struct {
    logic [63:0] data;
    int          base;
    logic [31:0] addr;
  } sb_t;

  sb_t         sb_q[$];
  logic [29:0] fill_q[$];

  bit          ref_valid [LINES];
  logic [31:0] ref_tag   [LINES];

  int  stall_total = 0;
  int  stall_at    = 0;
  int  wait_cnt    = 0;
  bit  req_active  = 0;
  bit  req_done    = 0;

  bit          in_fill   = 0;
  int          beat      = 0;
  int          wait_left = 0;
  logic [29:0] fill_line = '0;
  bit          rand_waits = 0;
  int          plan [4] = '{0, 0, 0, 0};

  function automatic int next_wait(input int b);
    if (rand_waits) return $urandom_range(0, 2);
    return plan[b];
  endfunction

  // RAM responder: checks every fill address against the line the model expects.
  always @(negedge clk) begin
    if (rst) begin
      in_fill   = 0;
      beat      = 0;
      wait_left = 0;
      mem_wait  = 1'b0;
    end else if (mem_rd) begin
      if (!in_fill) begin
        in_fill = 1;
        beat    = 0;
        if (fill_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_fill: got mem_rd=1 at %h expected no fill", mem_addr);
          fill_line = mem_addr[31:2];
        end else begin
          fill_line = fill_q.pop_front();
        end
        wait_left = next_wait(0);
      end
      check("mem_addr", 64'(mem_addr), 64'({fill_line, beat[1:0]}));
      if (wait_left > 0) begin
        mem_wait = 1'b1;
        wait_left--;
        stall_total++;
      end else begin
        mem_wait = 1'b0;
        if (beat == 3) begin
          in_fill = 0;
        end else begin
          beat++;
          wait_left = next_wait(beat);
        end
      end
    end else begin
      if (in_fill) begin
        check("mem_rd_held", 64'(mem_rd), 64'd1);
        in_fill = 0;
      end
      mem_wait = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: completes a request when the DUT presents the line.
  always @(negedge clk) begin
    sb_t e;
    if (!rst && req_active && fetch_en) begin
      if (cache_wait) begin
        wait_cnt++;
      end else if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty: got line %h expected no output", cache_dat);
        req_active = 0;
        req_done   = 1;
      end else begin
        e = sb_q.pop_front();
        check("cache_dat", cache_dat, e.data);
        check("wait_cycles", 64'(wait_cnt), 64'(e.base + stall_total - stall_at));
        req_active = 0;
        req_done   = 1;
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < LINES; i++) ref_valid[i] = 0;
  endtask

  // mode 0: plain fetch, 1: inv with the request cycle, 2: inv pulsed during beat 1 of the fill
  task automatic request(input logic [31:0] addr, input int mode);
    int          idx;
    int          cyc;
    logic [31:0] tag;
    bit          hit;
    bit          pulsed;
    sb_t         e;
    idx = int'((addr >> 2) % LINES);
    tag = addr >> (2 + IDX_W);
    hit = ref_valid[idx] && (ref_tag[idx] == tag);
    if (hit && mode == 2) mode = 0;
    e.data = line_data(addr[31:2]);
    e.base = hit ? 0 : ((mode == 2) ? 10 : 5);
    e.addr = addr;
    sb_q.push_back(e);
    if (!hit) fill_q.push_back(addr[31:2]);
    if (mode == 2) fill_q.push_back(addr[31:2]);
    stall_at   = stall_total;
    wait_cnt   = 0;
    req_done   = 0;
    req_active = 1;
    fetch_en   = 1'b1;
    fetch_addr = addr;
    inv        = (mode == 1);
    pulsed     = 0;
    cyc        = 0;
    while (!req_done && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      inv = 1'b0;
      if (mode == 2 && !pulsed && in_fill && beat == 1) begin
        inv    = 1'b1;
        pulsed = 1;
      end
    end
    inv = 1'b0;
    if (!req_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL request_timeout: got no line after %0d cycles expected line for %h", cyc, addr);
      finish_run();
    end
    if (mode != 0) clear_model();
    if (!hit) begin
      ref_valid[idx] = 1;
      ref_tag[idx]   = tag;
    end
  endtask

  task automatic idle_cycle(input bit do_inv);
    fetch_en = 1'b0;
    inv      = do_inv;
    @(posedge clk);
    #1;
    inv = 1'b0;
    if (do_inv) clear_model();
  endtask

  initial begin
    int          cyc;
    logic [31:0] a;
    int          r;
    rst        = 1'b1;
    fetch_en   = 1'b0;
    fetch_addr = '0;
    inv        = 1'b0;
    mem_wait   = 1'b0;
    clear_model();

    @(negedge clk);
    check("reset_mem_rd", 64'(mem_rd), 64'd0);
    check("reset_mem_addr", 64'(mem_addr), 64'd0);
    check("reset_wait_idle", 64'(cache_wait), 64'd0);
    fetch_en = 1'b1;
    @(negedge clk);
    check("reset_wait_fetch", 64'(cache_wait), 64'd1);
    fetch_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    rand_waits = 0;
    plan = '{0, 0, 0, 0};
    request(32'h0000_0000, 0);
    check("cold_line_value", cache_dat, 64'h4444_3333_2222_1111);
    request(32'h0000_0002, 0);
    request(32'h0000_0040, 0);
    plan = '{0, 0, 3, 0};
    request(32'h0000_0000, 0);
    plan = '{0, 0, 0, 0};
    request(32'h0000_0000, 2);
    request(32'h0000_0001, 0);

    // Reset in the middle of a fill, at beat 2.
    fill_q.push_back(30'h10);
    fetch_en   = 1'b1;
    fetch_addr = 32'h0000_0040;
    cyc = 0;
    while (!(in_fill && beat == 2) && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("reach_beat2", 64'(in_fill && beat == 2), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mem_rd", 64'(mem_rd), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_wait", 64'(cache_wait), 64'd1);
    fill_q.delete();
    clear_model();
    @(posedge clk);
    #1;
    fetch_en = 1'b0;
    rst      = 1'b0;
    @(posedge clk);
    #1;
    request(32'h0000_0040, 0);
    request(32'h0000_0043, 0);

    rand_waits = 1;
    for (int n = 0; n < 200; n++) begin
      a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, LINES - 1) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 15) == 0) a = a | ($urandom() & 32'hFFFF_FF00);
      r = $urandom_range(0, 19);
      if (r == 0)      idle_cycle(1);
      else if (r == 1) idle_cycle(0);
      if (r == 2)      request(a, 1);
      else if (r == 3) request(a, 2);
      else             request(a, 0);
    end

    idle_cycle(0);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    check("fills_drained", 64'(fill_q.size()), 64'd0);
    finish_run();
  end

endmodule
